// File: rtl/clk_div_align_ctrl.sv
// Divider soft-reset, settle and bit-slip alignment sequencer for one receive lane.
// Defining CLK_DIV_ALIGN_MONITOR_EN adds an in-DONE link monitor that re-aligns after 4 bad words.
module clk_div_align_ctrl #(
  parameter int unsigned       DATA_W        = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'hB4,
  parameter int unsigned       SRESET_CYCLES = 16,
  parameter int unsigned       SETTLE_CYCLES = 8,
  parameter int unsigned       MATCH_COUNT   = 4,
  parameter int unsigned       MAX_SLIPS     = 8
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  input  logic              pll_lock_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              div_sreset_n_o,
  output logic              bit_slip_o,
  output logic              align_done_o,
  output logic              align_fail_o,
  output logic [7:0]        slip_cnt_o
);

  localparam int unsigned CNT_MAX_A = (SRESET_CYCLES > SETTLE_CYCLES) ? SRESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > MATCH_COUNT) ? CNT_MAX_A : MATCH_COUNT;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SRESET_LD  = CNT_W'(SRESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MATCH_LAST = CNT_W'(MATCH_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]       SLIP_MAX   = 8'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SRESET    = 3'd2,
    S_SETTLE    = 3'd3,
    S_CHECK     = 3'd4,
    S_SLIP      = 3'd5,
    S_DONE      = 3'd6,
    S_FAIL      = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [7:0]       slip_cnt_q, slip_cnt_d;
  logic             div_sreset_n_q, div_sreset_n_d;
  logic             bit_slip_q, bit_slip_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             lock_lost_s;
  logic             word_ok_s;
`ifdef CLK_DIV_ALIGN_MONITOR_EN
  logic [1:0]       mon_q, mon_d;
`endif

  assign lock_lost_s = !pll_lock_i && (state_q != S_IDLE) && (state_q != S_WAIT_LOCK);
  assign word_ok_s   = (rx_data_i == TRAIN_PATTERN);

  // Next-state and next-output logic; lock loss overrides every other transition
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    match_d        = match_q;
    slip_cnt_d     = slip_cnt_q;
    div_sreset_n_d = div_sreset_n_q;
    bit_slip_d     = 1'b0;
    done_d         = done_q;
    fail_d         = fail_q;
`ifdef CLK_DIV_ALIGN_MONITOR_EN
    mon_d          = mon_q;
`endif
    if (lock_lost_s) begin
      state_d        = S_WAIT_LOCK;
      cnt_d          = '0;
      match_d        = '0;
      slip_cnt_d     = 8'd0;
      div_sreset_n_d = 1'b0;
      done_d         = 1'b0;
      fail_d         = 1'b0;
`ifdef CLK_DIV_ALIGN_MONITOR_EN
      mon_d          = 2'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_FAIL: begin
          if (start_i) begin
            state_d        = S_WAIT_LOCK;
            cnt_d          = '0;
            match_d        = '0;
            slip_cnt_d     = 8'd0;
            div_sreset_n_d = 1'b0;
            done_d         = 1'b0;
            fail_d         = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_WAIT_LOCK: begin
          div_sreset_n_d = 1'b0;
          if (pll_lock_i) begin
            state_d = S_SRESET;
            cnt_d   = SRESET_LD;
          end else begin
            state_d = S_WAIT_LOCK;
          end
        end
        S_SRESET: begin
          if (cnt_q == '0) begin
            state_d        = S_SETTLE;
            cnt_d          = SETTLE_LD;
            div_sreset_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = S_CHECK;
            match_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_CHECK: begin
          if (word_ok_s) begin
            if (match_q == MATCH_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
`ifdef CLK_DIV_ALIGN_MONITOR_EN
              mon_d   = 2'd0;
`endif
            end else begin
              match_d = match_q + CNT_ONE;
            end
          end else if (slip_cnt_q >= SLIP_MAX) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d    = S_SLIP;
            bit_slip_d = 1'b1;
            slip_cnt_d = slip_cnt_q + 8'd1;
          end
        end
        S_SLIP: begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end
        S_DONE: begin
          if (start_i) begin
            state_d        = S_WAIT_LOCK;
            cnt_d          = '0;
            match_d        = '0;
            slip_cnt_d     = 8'd0;
            div_sreset_n_d = 1'b0;
            done_d         = 1'b0;
            fail_d         = 1'b0;
`ifdef CLK_DIV_ALIGN_MONITOR_EN
          end else if (word_ok_s) begin
            mon_d = 2'd0;
          end else if (mon_q == 2'd3) begin
            // Link drifted: re-align through SETTLE, divider stays out of reset
            state_d    = S_SETTLE;
            cnt_d      = SETTLE_LD;
            done_d     = 1'b0;
            slip_cnt_d = 8'd0;
            mon_d      = 2'd0;
          end else begin
            mon_d = mon_q + 2'd1;
          end
`else
          end else begin
            state_d = S_DONE;
          end
`endif
        end
        default: begin
          state_d        = S_IDLE;
          div_sreset_n_d = 1'b1;
        end
      endcase
    end
  end

  // State, counters and registered outputs with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      match_q        <= '0;
      slip_cnt_q     <= 8'd0;
      div_sreset_n_q <= 1'b1;
      bit_slip_q     <= 1'b0;
      done_q         <= 1'b0;
      fail_q         <= 1'b0;
`ifdef CLK_DIV_ALIGN_MONITOR_EN
      mon_q          <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      match_q        <= match_d;
      slip_cnt_q     <= slip_cnt_d;
      div_sreset_n_q <= div_sreset_n_d;
      bit_slip_q     <= bit_slip_d;
      done_q         <= done_d;
      fail_q         <= fail_d;
`ifdef CLK_DIV_ALIGN_MONITOR_EN
      mon_q          <= mon_d;
`endif
    end
  end

  assign div_sreset_n_o = div_sreset_n_q;
  assign bit_slip_o     = bit_slip_q;
  assign align_done_o   = done_q;
  assign align_fail_o   = fail_q;
  assign slip_cnt_o     = slip_cnt_q;

endmodule
